// File: rtl/logmul_pkg.sv
// Shared widths and FSM state encoding for the Mitchell-log front end.
package logmul_pkg;
  localparam int DW = 8;           // operand width
  localparam int KW = 3;           // characteristic width, log2(DW)
  localparam int LW = KW + DW - 1; // log word {k, m}
  localparam int SW = LW + 1;      // log_a + log_b

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;
endpackage

// File: rtl/lod_scan.sv
// Serial leading-one detector for one operand: shifts left until bit DW-1 is set,
// counting the characteristic down and keeping the bits below the leading one.
module lod_scan #(
  parameter int DW = 8,
  parameter int KW = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [DW-1:0]      operand,
  output logic               done_next,
  output logic [KW+DW-2:0]   log_val,
  output logic               zero
);
  logic [DW-1:0] sr;
  logic [KW-1:0] k;
  logic [DW-2:0] mant;
  logic          done;
  logic          op_zero;

  assign op_zero = (operand == '0);

  // NOTE: all state here is reset synchronously; sequential state uses <= only
  // so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= '0;
      k    <= '0;
      mant <= '0;
      done <= 1'b0;
      zero <= 1'b0;
    end else if (load) begin
      sr   <= operand;
      k    <= op_zero ? '0 : KW'(DW - 1);
      mant <= '0;
      done <= op_zero;
      zero <= op_zero;
    end else if (step && !done) begin
      if (sr[DW-1]) begin
        done <= 1'b1;
        mant <= sr[DW-2:0];
      end else begin
        sr <= {sr[DW-2:0], 1'b0};
        k  <= k - 1'b1;
      end
    end
  end

  // Look-ahead so the FSM can leave SCAN on the same edge the last operand finishes.
  assign done_next = done | sr[DW-1];
  assign log_val   = done ? {k, mant} : {k, sr[DW-2:0]};
endmodule

// File: rtl/logval_seq.sv
// Sequential Mitchell-log stage: finds log2 of two operands by serial scan and
// presents both logs plus their sum, with valid/ready handshakes on both sides.
module logval_seq
  import logmul_pkg::state_t;
#(
  parameter int DW = logmul_pkg::DW,
  parameter int KW = logmul_pkg::KW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      n_var_1,
  input  logic [DW-1:0]      n_var_2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [KW+DW-2:0]   log_a,
  output logic [KW+DW-2:0]   log_b,
  output logic [KW+DW-1:0]   log_sum,
  output logic               zero
);
  localparam int LW = KW + DW - 1;

  state_t        state;
  logic          load;
  logic          step;
  logic          done_a, done_b;
  logic          zero_a, zero_b;
  logic [LW-1:0] lv_a, lv_b;
  logic [LW:0]   sum_next;

  assign in_ready = (state == logmul_pkg::IDLE);
  assign load     = in_ready && in_valid;
  assign step     = (state == logmul_pkg::SCAN);
  assign sum_next = {1'b0, lv_a} + {1'b0, lv_b};

  lod_scan #(.DW(DW), .KW(KW)) u_scan_a (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .operand   (n_var_1),
    .done_next (done_a),
    .log_val   (lv_a),
    .zero      (zero_a)
  );

  lod_scan #(.DW(DW), .KW(KW)) u_scan_b (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .operand   (n_var_2),
    .done_next (done_b),
    .log_val   (lv_b),
    .zero      (zero_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= logmul_pkg::IDLE;
      out_valid <= 1'b0;
      log_a     <= '0;
      log_b     <= '0;
      log_sum   <= '0;
      zero      <= 1'b0;
    end else begin
      case (state)
        logmul_pkg::IDLE: begin
          if (in_valid) state <= logmul_pkg::SCAN;
        end
        logmul_pkg::SCAN: begin
          if (done_a && done_b) begin
            state     <= logmul_pkg::DONE;
            out_valid <= 1'b1;
            log_a     <= lv_a;
            log_b     <= lv_b;
            zero      <= zero_a | zero_b;
            // A zero product has no meaningful log, so the antilog input is cleared.
            log_sum   <= (zero_a | zero_b) ? '0 : sum_next;
          end
        end
        logmul_pkg::DONE: begin
          if (out_ready) begin
            state     <= logmul_pkg::IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= logmul_pkg::IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_logval_seq.sv
// Scoreboard bench for logval_seq: the driver pushes hand-computed expectations,
// a negedge monitor checks latency, stability and values at each handshake.
module tb_logval_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  n_var_1, n_var_2;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  log_a, log_b;
  logic [10:0] log_sum;
  logic        zero;

  typedef struct {
    int la;
    int lb;
    int sum;
    int z;
    int lat;
    int acc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          seen = 1'b0;
  logic [31:0] snap;

  logval_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n_var_1   (n_var_1),
    .n_var_2   (n_var_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .log_a     (log_a),
    .log_b     (log_b),
    .log_sum   (log_sum),
    .zero      (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (rst !== 1'b1 && out_valid === 1'b1) begin
      check("in_ready_low_in_done", int'(in_ready), 0);
      if (sb.size() == 0) begin
        check("spurious_out_valid", 1, 0);
      end else begin
        if (!seen) begin
          check("latency", cyc - sb[0].acc, sb[0].lat);
          snap = {log_a, log_b, log_sum, zero};
          seen = 1'b1;
        end else begin
          check("stable_outputs", int'({log_a, log_b, log_sum, zero}), int'(snap));
        end
        if (out_ready === 1'b1) begin
          check("log_a", int'(log_a), sb[0].la);
          check("log_b", int'(log_b), sb[0].lb);
          check("log_sum", int'(log_sum), sb[0].sum);
          check("zero", int'(zero), sb[0].z);
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    int n;
    @(negedge clk);
    n_var_1  = a;
    n_var_2  = b;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) check("accept_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input int la,
                      input int lb, input int sum, input int z, input int lat);
    exp_t e;
    accept(a, b);
    e.la = la; e.lb = lb; e.sum = sum; e.z = z; e.lat = lat; e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("result_timeout", 1, 0);
      sb.delete();
      seen = 1'b0;
    end
  endtask

  initial begin
    int hits;
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; n_var_1 = '0; n_var_2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_log_a", int'(log_a), 0);
    check("rst_log_b", int'(log_b), 0);
    check("rst_log_sum", int'(log_sum), 0);
    check("rst_zero", int'(zero), 0);

    // a, b, log_a, log_b, log_sum, zero, latency
    send(8'd200, 8'd3,   968,  192,  1160, 0, 7); wait_empty();
    send(8'd128, 8'd1,   896,  0,    896,  0, 8); wait_empty();
    send(8'd255, 8'd255, 1023, 1023, 2046, 0, 1); wait_empty();
    send(8'd0,   8'd77,  0,    794,  0,    1, 2); wait_empty();
    send(8'd77,  8'd0,   794,  0,    0,    1, 2); wait_empty();
    send(8'd0,   8'd0,   0,    0,    0,    1, 1); wait_empty();

    // Consumer stall: hold out_ready low for 5 cycles in DONE.
    out_ready = 1'b0;
    send(8'd5, 8'd6, 288, 320, 608, 0, 6);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("stall_out_valid_seen", int'(out_valid), 1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_handshake_in_ready", int'(in_ready), 1);
    check("post_handshake_out_valid", int'(out_valid), 0);
    wait_empty();

    // Abort mid-scan with reset: no result may appear.
    accept(8'd1, 8'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_log_a", int'(log_a), 0);
    check("abort_log_sum", int'(log_sum), 0);
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) hits++;
    end
    check("abort_no_out_valid", hits, 0);

    send(8'd2, 8'd2, 128, 128, 256, 0, 7); wait_empty();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
